cfg_stream_loader: RTL and testbench
====================================

Name: cfg_stream_loader

Overview:
- Configuration controller for one data_connection_block instance.
- Accepts a configuration bitstream as WORD-bit words over a valid/ready stream and assembles it in a shadow register.
- On a complete, well-formed frame, commits the shadow atomically to the block's config bus c and pulses cset.
- Malformed or aborted frames never disturb the active configuration.

Parameters:
- W, 16, connection-block track width (used only to derive CFG_BITS).
- WW, 4, connection-block word width.
- DATAIN, 4, number of data inputs.
- DATAOUT, 3, number of data outputs.
- CFG_BITS, $clog2(2*W/WW)*DATAIN*WW + $clog2(DATAOUT+1)*W*2 (=112), width of c.
- WORD, 8, stream word width.
- NWORDS, (CFG_BITS+WORD-1)/WORD (=14), words per frame.

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame.
- abort  in  1  one-cycle request to cancel the current frame.
- in_data  in  WORD  stream word; LSB-first frame order.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  loader can accept a word.
- c  out  CFG_BITS  active config bus to data_connection_block.
- cset  out  1  one-cycle commit strobe to data_connection_block.
- busy  out  1  frame in progress (LOAD or COMMIT).
- done  out  1  one-cycle pulse when a commit occurs.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): c=0 (default pass-through configuration), shadow=0, cset=0, done=0, err=0, busy=0, in_ready=0, word counter=0, state=IDLE.
- All outputs are registered; in_ready=1 exactly when state==LOAD.
- A word is accepted on a rising edge with in_valid & in_ready.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - start=1 -> LOAD next cycle; counter=0, shadow=0, err=0.
  - in_valid in IDLE is not accepted and is ignored.
- LOAD, accept of word k (k = 0..NWORDS-1):
  - shadow[k*WORD +: WORD] <= in_data. For the final word, bits above CFG_BITS are dropped; 112/8 leaves no padding.
  - k < NWORDS-1 with in_last=1 -> early last: err=1, IDLE, shadow discarded.
  - k == NWORDS-1 with in_last=0 -> missing last: err=1, IDLE.
  - k == NWORDS-1 with in_last=1 -> COMMIT.
- COMMIT (exactly one cycle):
  - c <= shadow; cset=1 and done=1 for this one cycle; busy=1.
  - Next state IDLE.
  - Latency: the final accept edge to the c/cset update is 1 cycle.
  - A full frame takes NWORDS+1 cycles after start at full throughput.
- abort=1 in LOAD -> IDLE next cycle, err unchanged, c unchanged. abort in IDLE or COMMIT is ignored; a commit cannot be cancelled.
- Simultaneous abort and accept in LOAD: abort wins; the word is dropped and no commit occurs.
- start while busy is ignored; the frame continues.
- start and abort together in IDLE: start wins.
- Mid-frame reset: asynchronous clear to reset values; c returns to 0.
- c is stable except in the COMMIT cycle.
- The counter is $clog2(NWORDS+1) bits and never wraps, since the frame terminates at NWORDS.

Decomposition:
- Shared package cfg_pkg:
  - state enum {IDLE, LOAD, COMMIT};
  - function cb_cfg_bits(W,WW,DATAIN,DATAOUT) returning CFG_BITS, reused by the block, its testbench and a future switch-block loader.
- One natural sub-module: cfg_shadow_reg. It is the word-addressed shadow register with write-enable, word index and clear.
- The FSM, counter and active register stay in cfg_stream_loader.

Test Plan:
- Reset, then idle 5 cycles -> c==0, cset==0, in_ready==0, err==0; attached data_connection_block gives north_out==south_in and south_out==north_in.
- start, then 14 words 0x11,0x22,...,0xEE back-to-back, in_last on word 13 -> c==0xEEDDCCBBAA99887766554433221 1 in 14 bytes LSB-first (byte k = 0x11*(k+1)); cset and done high exactly 1 cycle, on the cycle after word 13; busy low the following cycle.
- Same frame with in_valid toggled every other cycle -> identical c; in_ready stays 1 throughout LOAD; commit occurs 1 cycle after the final accept.
- Commit a frame of all 0xFF, then send 10 words with in_last on word 9 -> err=1, no cset, c remains all ones.
- Start a frame, abort after word 6 -> IDLE next cycle, c unchanged, err=0; a subsequent full frame commits normally.
- Assert rst=0 asynchronously (between clock edges) mid-LOAD after a prior commit -> c==0 immediately, in_ready==0; start is accepted after rst returns high.
- Random-config end-to-end: for 100 random frames, the selector field for data_input index i*WW+j sits at bits [3*(i*WW+j) +: 3] in LSB-first order -> data_connection_block outputs match the golden model after each cset.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration stream loaders.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Config width of a connection block: per-input track selectors plus
  // per-track output selectors in both directions.
  function automatic int cb_cfg_bits(input int w, input int ww,
                                     input int datain, input int dataout);
    return $clog2(2 * w / ww) * datain * ww + $clog2(dataout + 1) * w * 2;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Word-addressed shadow register: collects a frame one word at a time.
// Also exposes its next value so a commit can include the word written
// on the same edge.
module cfg_shadow_reg #(
  parameter int CFG_BITS = 112,
  parameter int WORD     = 8,
  parameter int NWORDS   = 14,
  parameter int IW       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [IW-1:0]       idx,
  input  logic [WORD-1:0]     wdata,
  output logic [CFG_BITS-1:0] q,
  output logic [CFG_BITS-1:0] q_nxt
);

  localparam int SW = NWORDS * WORD;

  logic [SW-1:0] shad_q, shad_d;

  // Clear has priority over a word write; bits beyond CFG_BITS are padding.
  always_comb begin
    shad_d = shad_q;
    if (clr)     shad_d = '0;
    else if (we) shad_d[idx*WORD +: WORD] = wdata;
  end

  // Shadow storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shad_q <= '0;
    else      shad_q <= shad_d;
  end

  assign q     = shad_q[CFG_BITS-1:0];
  assign q_nxt = shad_d[CFG_BITS-1:0];

endmodule

// File: rtl/cfg_stream_loader.sv
// Loads a connection-block configuration frame from a valid/ready word
// stream and commits it atomically to the active config bus.
module cfg_stream_loader
  import cfg_pkg::*;
#(
  parameter int W        = 16,
  parameter int WW       = 4,
  parameter int DATAIN   = 4,
  parameter int DATAOUT  = 3,
  parameter int CFG_BITS = cb_cfg_bits(W, WW, DATAIN, DATAOUT),
  parameter int WORD     = 8,
  parameter int NWORDS   = (CFG_BITS + WORD - 1) / WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD-1:0]     in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] c,
  output logic                cset,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int          CW   = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] c_q, c_d;
  logic                cset_q, cset_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;

  logic                accept;
  logic                sh_clr, sh_we;
  logic [CFG_BITS-1:0] sh_q, sh_nxt;

  cfg_shadow_reg #(
    .CFG_BITS (CFG_BITS),
    .WORD     (WORD),
    .NWORDS   (NWORDS),
    .IW       (CW)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .we    (sh_we),
    .idx   (cnt_q),
    .wdata (in_data),
    .q     (sh_q),
    .q_nxt (sh_nxt)
  );

  // Frame FSM. The final accepted word commits straight from the shadow's
  // next value, so c and cset change together at the edge entering COMMIT
  // and are both visible for the single COMMIT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    err_d   = err_q;
    cset_d  = 1'b0;
    done_d  = 1'b0;
    sh_clr  = 1'b0;
    sh_we   = 1'b0;
    accept  = in_valid & in_ready_q;
    unique case (state_q)
      IDLE: begin
        // start beats a simultaneous abort simply because abort is unused here
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sh_clr  = 1'b1;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          // a word presented alongside abort is dropped
          state_d = IDLE;
        end else if (accept) begin
          sh_we = 1'b1;
          if (cnt_q == LAST) begin
            if (in_last) begin
              state_d = COMMIT;
              c_d     = sh_nxt;
              cset_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == LOAD);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      c_q        <= '0;
      cset_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      cset_q     <= cset_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign c        = c_q;
  assign cset     = cset_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Bench for cfg_stream_loader: directed frame scenarios plus random frames,
// with committed configs checked against a scoreboard of expected frames.
module tb_cfg_stream_loader;
  import cfg_pkg::*;

  localparam int CFG_BITS = cb_cfg_bits(16, 4, 4, 3);
  localparam int WORD     = 8;
  localparam int NWORDS   = (CFG_BITS + WORD - 1) / WORD;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [WORD-1:0]     in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic                in_ready;
  logic [CFG_BITS-1:0] c;
  logic                cset;
  logic                busy;
  logic                done;
  logic                err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_cset = 0;
  int n_exp  = 0;
  logic [CFG_BITS-1:0] sb[$];

  cfg_stream_loader #(
    .W(16), .WW(4), .DATAIN(4), .DATAOUT(3), .WORD(WORD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .c        (c),
    .cset     (cset),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every commit strobe must match the oldest expected frame.
  always begin
    @(posedge clk);
    #1;
    if (rst && (cset === 1'b1 || done === 1'b1)) begin
      chk("done_eq_cset", done, cset);
      if (cset === 1'b1) begin
        n_cset++;
        if (sb.size() == 0) chk("unexpected_cset", 1, 0);
        else                chk("c_commit", c, sb.pop_front());
      end
    end
  end

  task automatic pulse_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Drive one frame. last_idx/abort_at of -1 mean never; gap idles in_valid
  // one cycle before every word and also raises start mid-frame.
  task automatic send_frame(input logic [CFG_BITS-1:0] frm, input int n,
                            input int last_idx, input bit gap, input int abort_at,
                            input bit exp_commit, input bit sa);
    if (exp_commit) begin
      sb.push_back(frm);
      n_exp++;
    end
    pulse_start(sa);
    chk("ready_load", in_ready, 1);
    chk("err_clr_on_start", err, 0);
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready_gap", in_ready, 1);
      end
      in_data  = frm[k*WORD +: WORD];
      in_valid = 1'b1;
      in_last  = (k == last_idx);
      abort    = (k == abort_at);
      start    = (gap && k == 5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      abort    = 1'b0;
      start    = 1'b0;
      if (k == abort_at) break;
    end
    if (exp_commit) begin
      chk("cset_lat", cset, 1);
      chk("done_lat", done, 1);
      chk("busy_commit", busy, 1);
      chk("ready_commit", in_ready, 0);
      @(posedge clk); #1;
      chk("cset_1cyc", cset, 0);
      chk("done_1cyc", done, 0);
      chk("busy_after", busy, 0);
    end else begin
      chk("no_cset", cset, 0);
      chk("idle_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CFG_BITS-1:0] inc, ones, rnd;
    for (int k = 0; k < NWORDS; k++) inc[k*WORD +: WORD] = 8'(8'h11 * (k + 1));
    ones = '1;

    // Reset and idle
    #1;
    chk("rst_c", c, 0);
    chk("rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;  // ignored in IDLE
    in_data  = 8'hA5;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("idle_c", c, 0);
    chk("idle_cset", cset, 0);
    chk("idle_ready", in_ready, 0);
    chk("idle_err", err, 0);
    chk("idle_busy", busy, 0);

    // Back-to-back incrementing frame
    send_frame(inc, NWORDS, NWORDS-1, 1'b0, -1, 1'b1, 1'b0);
    chk("inc_c", c, {16'h0, 112'hEEDDCCBBAA99887766554433_2211});

    // Same frame with valid gaps and a stray start mid-frame
    send_frame(inc, NWORDS, NWORDS-1, 1'b1, -1, 1'b1, 1'b0);
    chk("gap_c", c, {16'h0, inc});

    // All ones, then an early-last frame
    send_frame(ones, NWORDS, NWORDS-1, 1'b0, -1, 1'b1, 1'b0);
    send_frame(inc, 10, 9, 1'b0, -1, 1'b0, 1'b0);
    chk("early_err", err, 1);
    chk("early_c", c, {16'h0, ones});

    // start+abort together (start wins, clears err); abort with word 7
    send_frame(inc, NWORDS, NWORDS-1, 1'b0, 7, 1'b0, 1'b1);
    chk("abort_err", err, 0);
    chk("abort_c", c, {16'h0, ones});

    // Missing last
    send_frame(inc, NWORDS, -1, 1'b0, -1, 1'b0, 1'b0);
    chk("miss_err", err, 1);
    chk("miss_c", c, {16'h0, ones});

    // Normal frame after errors
    send_frame(inc, NWORDS, NWORDS-1, 1'b0, -1, 1'b1, 1'b0);
    chk("recov_c", c, {16'h0, inc});

    // Asynchronous reset mid-load
    pulse_start(1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("arst_c", c, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_frame(ones, NWORDS, NWORDS-1, 1'b0, -1, 1'b1, 1'b0);
    chk("post_rst_c", c, {16'h0, ones});

    // Random frames
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < NWORDS; k++) rnd[k*WORD +: WORD] = 8'($urandom_range(255));
      send_frame(rnd, NWORDS, NWORDS-1, 1'($urandom_range(1)), -1, 1'b1, 1'b0);
      chk("rand_c", c, {16'h0, rnd});
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    chk("cset_count", n_cset, n_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
